// File: rtl/vic_pkg.sv
// Shared constants and types for the 80x60 text-mode video path.
// The scan-out stage imports the same geometry.
package vic_pkg;

    localparam int unsigned VIC_COLS  = 80;
    localparam int unsigned VIC_ROWS  = 60;
    localparam logic [7:0]  VIC_BLANK = 8'h20;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_SCROLL,
        ST_FILL
    } state_t;

endpackage

// File: rtl/text_console_writer_region_filler.sv
// Sequential writer over an inclusive address range [first_addr, last_addr].
// It emits one write per cycle starting the cycle after start, and done flags the final write.
module region_filler #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic              active;
    logic [ADDR_W-1:0] last_q;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            addr   <= '0;
            last_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            addr   <= first_addr;
            last_q <= last_addr;
        end else if (active) begin
            if (addr == last_q) begin
                active <= 1'b0;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign we   = active;
    assign done = active && (addr == last_q);

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text console: glyph/attribute writes at the cursor,
// control codes, line wrap, full-screen scroll and clear into dual-port video/colour RAMs.
module text_console_writer
    import vic_pkg::*;
#(
    parameter int unsigned COLS   = VIC_COLS,
    parameter int unsigned ROWS   = VIC_ROWS,
    parameter int unsigned ADDR_W = 13,
    parameter logic [7:0]  BLANK  = VIC_BLANK
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [7:0]        in_colour,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        vmem_wdata,
    output logic [7:0]        col_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [7:0]        vmem_rdata,
    input  logic [7:0]        col_rdata,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] A_COLS        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] A_SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] A_LAST_ROW    = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [6:0]        X_LAST        = 7'(COLS - 1);
    localparam logic [5:0]        Y_LAST        = 6'(ROWS - 1);

    state_t            state, state_n;
    logic [6:0]        x_q, x_n;
    logic [5:0]        y_q, y_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        code_q, colour_q;
    logic              ff_q;
    logic              xfer;
    logic              newline;
    logic              scroll_go;

    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic              rd_on, wr_on;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_first;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_done;

    region_filler #(
        .ADDR_W(ADDR_W)
    ) u_filler (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .start     (fill_start),
        .first_addr(fill_first),
        .last_addr (A_SCREEN_LAST),
        .we        (fill_we),
        .addr      (fill_addr),
        .done      (fill_done)
    );

    assign xfer      = in_valid && (state == ST_IDLE);
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign cursor_x  = x_q;
    assign cursor_y  = y_q;
    assign ram_raddr = rd_ptr;

    always_comb begin
        state_n    = state;
        x_n        = x_q;
        y_n        = y_q;
        addr_n     = addr_q;
        newline    = 1'b0;
        scroll_go  = 1'b0;
        fill_start = 1'b0;
        fill_first = A_LAST_ROW;
        ram_we     = 1'b0;
        ram_waddr  = addr_q;
        vmem_wdata = code_q;
        col_wdata  = colour_q;

        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    unique case (in_data)
                        CC_CR: begin
                            x_n    = '0;
                            addr_n = addr_q - ADDR_W'(x_q);
                        end
                        CC_LF: newline = 1'b1;
                        CC_BS: begin
                            if (x_q != '0) begin
                                x_n    = x_q - 7'd1;
                                addr_n = addr_q - ADDR_W'(1);
                            end
                        end
                        CC_FF: begin
                            fill_start = 1'b1;
                            fill_first = '0;
                            state_n    = ST_FILL;
                        end
                        default: state_n = ST_PUT;
                    endcase
                end
            end
            ST_PUT: begin
                ram_we  = 1'b1;
                state_n = ST_IDLE;
                if (x_q == X_LAST) begin
                    newline = 1'b1;
                end else begin
                    x_n    = x_q + 7'd1;
                    addr_n = addr_q + ADDR_W'(1);
                end
            end
            ST_SCROLL: begin
                ram_we     = wr_on;
                ram_waddr  = wr_ptr;
                vmem_wdata = vmem_rdata;
                col_wdata  = col_rdata;
                // Final copy write: hand the last row to the filler with no gap cycle.
                if (wr_on && !rd_on) begin
                    fill_start = 1'b1;
                    state_n    = ST_FILL;
                end
            end
            ST_FILL: begin
                ram_we     = fill_we;
                ram_waddr  = fill_addr;
                vmem_wdata = BLANK;
                if (fill_done) begin
                    state_n = ST_IDLE;
                    if (ff_q) begin
                        x_n    = '0;
                        y_n    = '0;
                        addr_n = '0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (newline) begin
            x_n = '0;
            if (y_q != Y_LAST) begin
                y_n    = y_q + 6'd1;
                addr_n = addr_q + (A_COLS - ADDR_W'(x_q));
            end else begin
                addr_n    = addr_q - ADDR_W'(x_q);
                scroll_go = 1'b1;
                state_n   = ST_SCROLL;
            end
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            code_q   <= '0;
            colour_q <= '0;
            ff_q     <= 1'b0;
        end else begin
            state  <= state_n;
            x_q    <= x_n;
            y_q    <= y_n;
            addr_q <= addr_n;
            if (xfer) begin
                code_q   <= in_data;
                colour_q <= in_colour;
                ff_q     <= (in_data == CC_FF);
            end
        end
    end

    // Read of row r+1 is issued one cycle ahead of the write to row r (1-cycle RAM latency).
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            rd_on  <= 1'b0;
            wr_on  <= 1'b0;
        end else if (scroll_go) begin
            rd_ptr <= A_COLS;
            wr_ptr <= '0;
            rd_on  <= 1'b1;
            wr_on  <= 1'b0;
        end else if (state == ST_SCROLL) begin
            wr_on <= rd_on;
            if (rd_on) begin
                if (rd_ptr == A_SCREEN_LAST) begin
                    rd_on <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
            if (wr_on) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer with a behavioural dual-port RAM pair.
module tb_text_console_writer;

    logic        pixclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [7:0]  in_colour = 8'h00;
    logic        ram_we;
    logic [12:0] ram_waddr;
    logic [7:0]  vmem_wdata;
    logic [7:0]  col_wdata;
    logic [12:0] ram_raddr;
    logic [7:0]  vmem_rdata;
    logic [7:0]  col_rdata;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;

    int total = 0;
    int bad = 0;
    int we_count = 0;

    logic [7:0] vmem [0:8191];
    logic [7:0] cmem [0:8191];

    always #5 pixclk = ~pixclk;

    text_console_writer #(
        .COLS(80),
        .ROWS(60),
        .ADDR_W(13),
        .BLANK(8'h20)
    ) dut (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_colour (in_colour),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .vmem_wdata(vmem_wdata),
        .col_wdata (col_wdata),
        .ram_raddr (ram_raddr),
        .vmem_rdata(vmem_rdata),
        .col_rdata (col_rdata),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    always @(posedge pixclk) begin
        if (ram_we) begin
            vmem[ram_waddr] <= vmem_wdata;
            cmem[ram_waddr] <= col_wdata;
            we_count <= we_count + 1;
        end
        vmem_rdata <= vmem[ram_raddr];
        col_rdata  <= cmem[ram_raddr];
    end

    // Called at posedge+#1; returns at posedge+#1 of the cycle after the transfer.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_colour = c;
        while (!in_ready && n < 10000) begin
            @(posedge pixclk); #1;
            n++;
        end
        if (n >= 10000) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge pixclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pixclk);
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", ram_we); end
        total++; if (ram_waddr !== 13'd0 || ram_raddr !== 13'd0) begin bad++; $display("FAIL reset_addr waddr=%0d raddr=%0d want=0", ram_waddr, ram_raddr); end
        total++; if (vmem_wdata !== 8'h00 || col_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h/%h want=00/00", vmem_wdata, col_wdata); end
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin bad++; $display("FAIL reset_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y); end
        @(posedge pixclk); #1;
    endtask

    task automatic test_put_a();
        send_byte(8'h41, 8'hE0);
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL put_we got=%b want=1", ram_we); end
        total++; if (ram_waddr !== 13'd0) begin bad++; $display("FAIL put_addr got=%0d want=0", ram_waddr); end
        total++; if (vmem_wdata !== 8'h41 || col_wdata !== 8'hE0) begin bad++; $display("FAIL put_data got=%h/%h want=41/e0", vmem_wdata, col_wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL put_ready_low got=%b want=0", in_ready); end
        @(posedge pixclk); #1;
        total++; if (in_ready !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL put_ready_back ready=%b we=%b want=1/0", in_ready, ram_we); end
        total++; if (cursor_x !== 7'd1 || cursor_y !== 6'd0) begin bad++; $display("FAIL put_cursor got=(%0d,%0d) want=(1,0)", cursor_x, cursor_y); end
        total++; if (vmem[0] !== 8'h41 || cmem[0] !== 8'hE0) begin bad++; $display("FAIL put_mem got=%h/%h want=41/e0", vmem[0], cmem[0]); end
    endtask

    task automatic test_ff();
        int w0;
        int n = 0;
        w0 = we_count;
        send_byte(8'h0C, 8'h03);
        while (busy && n < 6000) begin
            n++;
            @(posedge pixclk); #1;
        end
        total++; if (n != 4800) begin bad++; $display("FAIL ff_busy_cycles got=%0d want=4800", n); end
        total++; if (we_count - w0 != 4800) begin bad++; $display("FAIL ff_writes got=%0d want=4800", we_count - w0); end
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin bad++; $display("FAIL ff_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y); end
        total++; if (vmem[0] !== 8'h20 || cmem[0] !== 8'h03) begin bad++; $display("FAIL ff_first got=%h/%h want=20/03", vmem[0], cmem[0]); end
        total++; if (vmem[2401] !== 8'h20 || cmem[2401] !== 8'h03) begin bad++; $display("FAIL ff_mid got=%h/%h want=20/03", vmem[2401], cmem[2401]); end
        total++; if (vmem[4799] !== 8'h20 || cmem[4799] !== 8'h03) begin bad++; $display("FAIL ff_last got=%h/%h want=20/03", vmem[4799], cmem[4799]); end
    endtask

    task automatic test_row_wrap();
        for (int i = 0; i < 80; i++) begin
            send_byte(8'h42, 8'(i));
            total++; if (ram_we !== 1'b1 || ram_waddr !== 13'(i)) begin bad++; $display("FAIL wrap_addr[%0d] we=%b got=%0d want=%0d", i, ram_we, ram_waddr, i); end
        end
        @(posedge pixclk); #1;
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd1) begin bad++; $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,1)", cursor_x, cursor_y); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_no_scroll busy=%b want=0", busy); end
        total++; if (vmem[79] !== 8'h42 || cmem[79] !== 8'h4F) begin bad++; $display("FAIL wrap_mem79 got=%h/%h want=42/4f", vmem[79], cmem[79]); end
        total++; if (vmem[80] !== 8'h20) begin bad++; $display("FAIL wrap_mem80 got=%h want=20", vmem[80]); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        in_valid = 1'b1;
        in_data = 8'h43;
        in_colour = 8'h11;
        repeat (6) begin
            if (in_ready) acc++;
            @(posedge pixclk); #1;
        end
        in_valid = 1'b0;
        total++; if (acc != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", acc); end
        total++; if (cursor_x !== 7'd3 || cursor_y !== 6'd1) begin bad++; $display("FAIL b2b_cursor got=(%0d,%0d) want=(3,1)", cursor_x, cursor_y); end
        total++; if (vmem[82] !== 8'h43 || vmem[83] !== 8'h20) begin bad++; $display("FAIL b2b_mem got=%h,%h want=43,20", vmem[82], vmem[83]); end
    endtask

    task automatic test_cr_bs();
        int w0;
        send_byte(8'h0A, 8'h00);
        send_byte(8'h0A, 8'h00);
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL lf_cursor got=(%0d,%0d) ready=%b want=(0,3) 1", cursor_x, cursor_y, in_ready); end
        repeat (10) send_byte(8'h44, 8'h22);
        @(posedge pixclk); #1;
        w0 = we_count;
        total++; if (cursor_x !== 7'd10 || cursor_y !== 6'd3) begin bad++; $display("FAIL crbs_start got=(%0d,%0d) want=(10,3)", cursor_x, cursor_y); end
        send_byte(8'h08, 8'h00);
        total++; if (cursor_x !== 7'd9 || in_ready !== 1'b1) begin bad++; $display("FAIL bs_dec got=%0d ready=%b want=9 1", cursor_x, in_ready); end
        send_byte(8'h0D, 8'h00);
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL cr_cursor got=(%0d,%0d) ready=%b want=(0,3) 1", cursor_x, cursor_y, in_ready); end
        send_byte(8'h08, 8'h00);
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd3) begin bad++; $display("FAIL bs_at_zero got=(%0d,%0d) want=(0,3)", cursor_x, cursor_y); end
        total++; if (we_count != w0) begin bad++; $display("FAIL crbs_no_write got=%0d want=%0d", we_count, w0); end
        send_byte(8'h45, 8'h33);
        total++; if (ram_we !== 1'b1 || ram_waddr !== 13'd240) begin bad++; $display("FAIL crbs_addr we=%b got=%0d want=240", ram_we, ram_waddr); end
        @(posedge pixclk); #1;
    endtask

    task automatic test_scroll();
        int w0;
        int n = 0;
        repeat (56) send_byte(8'h0A, 8'h00);
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd59) begin bad++; $display("FAIL scr_lf_walk got=(%0d,%0d) want=(0,59)", cursor_x, cursor_y); end
        repeat (5) send_byte(8'h46, 8'h44);
        @(posedge pixclk); #1;
        total++; if (cursor_x !== 7'd5 || cursor_y !== 6'd59) begin bad++; $display("FAIL scr_start got=(%0d,%0d) want=(5,59)", cursor_x, cursor_y); end
        w0 = we_count;
        send_byte(8'h0A, 8'h5A);
        while (busy && n < 10000) begin
            n++;
            @(posedge pixclk); #1;
        end
        total++; if (n != 4801) begin bad++; $display("FAIL scr_cycles got=%0d want=4801", n); end
        total++; if (we_count - w0 != 4800) begin bad++; $display("FAIL scr_writes got=%0d want=4800", we_count - w0); end
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd59) begin bad++; $display("FAIL scr_cursor got=(%0d,%0d) want=(0,59)", cursor_x, cursor_y); end
        total++; if (vmem[0] !== 8'h43 || cmem[0] !== 8'h11 || vmem[2] !== 8'h43) begin bad++; $display("FAIL scr_row0 got=%h/%h,%h want=43/11,43", vmem[0], cmem[0], vmem[2]); end
        total++; if (vmem[3] !== 8'h20 || vmem[79] !== 8'h20) begin bad++; $display("FAIL scr_row0_tail got=%h,%h want=20,20", vmem[3], vmem[79]); end
        total++; if (vmem[160] !== 8'h45 || vmem[161] !== 8'h44 || cmem[161] !== 8'h22) begin bad++; $display("FAIL scr_row2 got=%h,%h/%h want=45,44/22", vmem[160], vmem[161], cmem[161]); end
        total++; if (vmem[4640] !== 8'h46 || cmem[4644] !== 8'h44 || vmem[4645] !== 8'h20) begin bad++; $display("FAIL scr_row58 got=%h,%h,%h want=46,44,20", vmem[4640], cmem[4644], vmem[4645]); end
        total++; if (vmem[4720] !== 8'h20 || cmem[4720] !== 8'h5A) begin bad++; $display("FAIL scr_blank_first got=%h/%h want=20/5a", vmem[4720], cmem[4720]); end
        total++; if (vmem[4799] !== 8'h20 || cmem[4799] !== 8'h5A) begin bad++; $display("FAIL scr_blank_last got=%h/%h want=20/5a", vmem[4799], cmem[4799]); end
    endtask

    task automatic test_reset_mid_scroll();
        send_byte(8'h0A, 8'h00);
        repeat (100) @(posedge pixclk);
        #1;
        total++; if (ram_we !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_active we=%b busy=%b want=1/1", ram_we, busy); end
        rst_n = 1'b0;
        #1;
        total++; if (ram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst we=%b busy=%b want=0/0", ram_we, busy); end
        @(posedge pixclk); #1;
        total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || ram_we !== 1'b0) begin bad++; $display("FAIL mid_rst_cursor got=(%0d,%0d) we=%b want=(0,0) 0", cursor_x, cursor_y, ram_we); end
        rst_n = 1'b1;
        @(posedge pixclk); #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_release ready=%b busy=%b want=1/0", in_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_put_a();
        test_ff();
        test_row_wrap();
        test_back_to_back();
        test_cr_bs();
        test_scroll();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
